// File: rtl/classifier_head.sv
// Final linear classifier: per-class bias + 16-term dot product on one shared
// multiplier, requantised to int8 logits plus an argmax class ID.
module classifier_head #(
  parameter int NUM_CLASS = 5,
  parameter int VEC_LEN   = 16,
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] vec_in   [VEC_LEN],
  input  logic signed [7:0] weight   [NUM_CLASS][VEC_LEN],
  input  logic signed [15:0] bias    [NUM_CLASS],
  output logic signed [7:0] logits   [NUM_CLASS],
  output logic        [2:0] class_id,
  output logic              busy,
  output logic              done
);

  localparam int KW = $clog2(VEC_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;

  localparam logic [KW-1:0]          K_LAST = KW'(VEC_LEN - 1);
  localparam logic [2:0]             C_LAST = 3'(NUM_CLASS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

  logic [1:0]              state_q, state_d;
  logic [2:0]              c_q, c_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] best_acc_q, best_acc_d;
  logic [2:0]              best_idx_q, best_idx_d;
  logic signed [7:0]       vec_q [VEC_LEN];
  logic signed [7:0]       vec_d [VEC_LEN];
  logic signed [7:0]       logits_q [NUM_CLASS];
  logic signed [7:0]       logits_d [NUM_CLASS];
  logic [2:0]              class_id_q, class_id_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] shifted;
  logic signed [7:0]       sat_val;
  logic                    take_best;

  // The single shared multiplier; 8x8 signed always fits in 16 bits.
  assign prod     = vec_q[k_q] * weight[c_q][k_q];
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign bias_ext = {{(ACC_W-16){bias[c_q][15]}}, bias[c_q]};
  assign shifted  = acc_q >>> SHIFT;

  always_comb begin
    sat_val = shifted[7:0];
    if (shifted > SAT_HI)      sat_val = 8'sd127;
    else if (shifted < SAT_LO) sat_val = -8'sd128;
  end

  // Strict compare on full-precision sums keeps ties on the lowest index.
  assign take_best = (c_q == 3'd0) || (acc_q > best_acc_q);

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    k_d        = k_q;
    acc_d      = acc_q;
    best_acc_d = best_acc_q;
    best_idx_d = best_idx_q;
    vec_d      = vec_q;
    logits_d   = logits_q;
    class_id_d = class_id_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = vec_in;
          c_d     = 3'd0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = (k_q == '0) ? (bias_ext + prod_ext) : (acc_q + prod_ext);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_STORE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_STORE: begin
        logits_d[c_q] = sat_val;
        if (take_best) begin
          best_acc_d = acc_q;
          best_idx_d = c_q;
        end
        if (c_q != C_LAST) begin
          c_d     = c_q + 3'd1;
          state_d = S_MAC;
        end else begin
          class_id_d = take_best ? c_q : best_idx_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      c_q        <= 3'd0;
      k_q        <= '0;
      acc_q      <= '0;
      best_acc_q <= '0;
      best_idx_q <= 3'd0;
      for (int i = 0; i < VEC_LEN; i++) vec_q[i] <= '0;
      for (int i = 0; i < NUM_CLASS; i++) logits_q[i] <= '0;
      class_id_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      best_acc_q <= best_acc_d;
      best_idx_q <= best_idx_d;
      vec_q      <= vec_d;
      logits_q   <= logits_d;
      class_id_q <= class_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign logits   = logits_q;
  assign class_id = class_id_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_classifier_head.sv
// Scoreboard bench for classifier_head: the driver queues expected results,
// a negedge monitor checks them whenever done pulses.
module tb_classifier_head;

  localparam int NC = 5;
  localparam int VL = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic signed [7:0] vec_in [VL];
  logic signed [7:0] weight [NC][VL];
  logic signed [15:0] bias  [NC];
  logic signed [7:0] logits [NC];
  logic        [2:0] class_id;
  logic              busy;
  logic              done;

  classifier_head dut (
    .clk(clk), .rst(rst), .start(start), .vec_in(vec_in), .weight(weight),
    .bias(bias), .logits(logits), .class_id(class_id), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lg [NC];
    int cls;
    int dcyc;
    string name;
  } exp_t;

  exp_t sb [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_done_cycle"}, cyc, e.dcyc);
          for (int i = 0; i < NC; i++)
            chk($sformatf("%s_logit%0d", e.name, i), int'(logits[i]), e.lg[i]);
          chk({e.name, "_class_id"}, int'(class_id), e.cls);
          $display("txn %s: logits %0d %0d %0d %0d %0d class %0d at cycle %0d",
                   e.name, logits[0], logits[1], logits[2], logits[3], logits[4],
                   class_id, cyc);
        end
      end
    end
  end

  task automatic pulse_start(output int e0);
    start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic push_exp(input string name, input int l0, input int l1,
                          input int l2, input int l3, input int l4,
                          input int cls, input int e0);
    exp_t e;
    e.lg[0] = l0; e.lg[1] = l1; e.lg[2] = l2; e.lg[3] = l3; e.lg[4] = l4;
    e.cls = cls; e.dcyc = e0 + 85; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 1, 0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input int v, input int wmode, input int b0,
                            input int b1, input int b2, input int b3, input int b4);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < VL; k++)
        weight[c][k] = (wmode < 0) ? 8'(c) : 8'(wmode);
    for (int k = 0; k < VL; k++) vec_in[k] = 8'(v);
    bias[0] = 16'(b0); bias[1] = 16'(b1); bias[2] = 16'(b2);
    bias[3] = 16'(b3); bias[4] = 16'(b4);
  endtask

  initial begin
    int e0, e1, busy_bad;
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_class_id", int'(class_id), 0);
    chk("reset_logit0", int'(logits[0]), 0);
    @(posedge clk); #1;

    // Case 1: logits equal the class weight; busy spans E0..E0+84.
    set_inputs(1, -1, 0, 0, 0, 0, 0);
    pulse_start(e0);
    push_exp("ramp", 0, 1, 2, 3, 4, 4, e0);
    busy_bad = 0;
    for (int i = 0; i < 85; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
    end
    chk("ramp_busy_cycles_low", busy_bad, 0);
    @(negedge clk);
    chk("ramp_busy_after", int'(busy), 0);
    wait_drain("ramp");

    set_inputs(127, 127, 0, 0, 0, 0, 0);
    pulse_start(e0);
    push_exp("sat_pos", 127, 127, 127, 127, 127, 0, e0);
    wait_drain("sat_pos");

    set_inputs(-128, 127, 0, 0, 0, 0, 0);
    pulse_start(e0);
    push_exp("sat_neg", -128, -128, -128, -128, -128, 0, e0);
    wait_drain("sat_neg");

    set_inputs(0, 0, 16, -32, 320, -48, 320);
    pulse_start(e0);
    push_exp("bias_tie", 1, -2, 20, -3, 20, 2, e0);
    wait_drain("bias_tie");

    // Case 5: starts at E0+40 and E0+85 ignored; E0+86 accepted.
    set_inputs(1, -1, 0, 0, 0, 0, 0);
    pulse_start(e0);
    push_exp("busy_start", 0, 1, 2, 3, 4, 4, e0);
    repeat (39) @(posedge clk); #1;
    pulse_start(e1);
    chk("extra_start_edge40", e1 - e0, 40);
    repeat (44) @(posedge clk); #1;
    pulse_start(e1);
    chk("extra_start_edge85", e1 - e0, 85);
    pulse_start(e1);
    push_exp("restart", 0, 1, 2, 3, 4, 4, e1);
    wait_drain("restart");

    // Case 6: reset at E0+30 aborts silently, then a clean rerun.
    set_inputs(127, 127, 0, 0, 0, 0, 0);
    pulse_start(e0);
    push_exp("pre_abort", 127, 127, 127, 127, 127, 0, e0);
    wait_drain("pre_abort");
    set_inputs(1, -1, 0, 0, 0, 0, 0);
    pulse_start(e0);
    repeat (29) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_logit0", int'(logits[0]), 0);
    chk("abort_logit4", int'(logits[4]), 0);
    chk("abort_class_id", int'(class_id), 0);
    repeat (100) @(posedge clk); #1;
    pulse_start(e0);
    push_exp("after_abort", 0, 1, 2, 3, 4, 4, e0);
    wait_drain("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
